popcount_accum: RTL and testbench
=================================

# popcount_accum

Streaming, parametrised population-count accumulator. Each accepted beat of WIDTH bits contributes its count of set bits to a per-frame running sum. The sum is emitted with the frame's beat count on a single-entry output register when the beat marked `in_last` is accepted. The block supersedes the fixed 4-input one-hot bit counter and sits between the sample capture front end and the statistics/threshold logic.

## Interface
Parameters:
- WIDTH, 8, bits per input beat (≥1)
- ACC_W, 16, width of the frame sum; must satisfy ACC_W ≥ clog2(WIDTH+1)
- BEAT_W, 8, width of the frame beat counter

Ports:
- clk  in  1  single clock; all logic is rising-edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  WIDTH  beat to be counted
- in_last  in  1  final beat of the frame
- out_valid  out  1  frame result held
- out_ready  in  1  downstream accepts result
- out_sum  out  ACC_W  total set bits in the frame
- out_beats  out  BEAT_W  beats in the frame, including the last
- out_ovf  out  1  frame sum exceeded 2^ACC_W−1

## Operation
- A beat is accepted when in_valid && in_ready.
- pc = popcount(in_data). This is a combinational adder tree, CNT_W = clog2(WIDTH+1) bits, zero-extended to ACC_W+1 before addition.
- Internal registers: acc (ACC_W), beats (BEAT_W), ovf (1).
- State ACCUM (out_valid=0), on an accepted non-last beat:
  - acc ← acc+pc, with overflow handling per Configuration.
  - beats ← beats+1, wrapping modulo 2^BEAT_W.
  - ovf ← ovf | carry.
- State ACCUM, on an accepted last beat:
  - out_sum ← acc+pc, out_beats ← beats+1, out_ovf ← ovf | carry.
  - acc, beats and ovf are cleared to 0.
  - Next state is FULL.
- State FULL (out_valid=1):
  - Outputs are held stable until out_ready.
  - Handshake at out_valid && out_ready returns the block to ACCUM, unless a last beat is accepted in the same cycle, in which case it stays FULL with the new result loaded.
- in_ready = !out_valid || out_ready. Input stalls only while a result is held and not being taken.
- Single-beat frame (in_last on first beat): out_sum = pc, out_beats = 1.
- Backpressure: in_data and in_last may change freely while in_ready=0. No beat is consumed.
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_beats=0, out_ovf=0, acc=0, beats=0, ovf=0, state ACCUM.
- Reset asserted mid-frame discards the partial frame and any held result.

## Timing
- Input to accumulation takes 1 cycle. The popcount is not registered separately.
- Latency from acceptance of the last beat to out_valid=1 is 1 cycle (next rising edge).
- Throughput is one beat per cycle sustained while out_ready=1, including back-to-back frames.
- in_ready depends combinationally on out_ready. There are no other combinational in→out paths.
- Reset assertion is asynchronous; deassertion is synchronised externally.

## Configuration
- POPCOUNT_ACCUM_SAT_EN:
  - Defined: acc, and out_sum on a last beat, saturate at 2^ACC_W−1. Once saturated they remain there for the rest of the frame.
  - Undefined: the sum wraps modulo 2^ACC_W.
- out_ovf is produced identically in both builds: sticky per frame, set on any carry out of ACC_W.

## Test plan
- WIDTH=4: beats 4'b1111, 4'b0101, 4'b0000 (last) with out_ready=1 → out_valid for 1 cycle with out_sum=6, out_beats=3, out_ovf=0.
- Single-beat frame 4'b1011 (last) → out_sum=3, out_beats=1. Next frame 4'b0001 (last) back-to-back → out_sum=1 the following cycle, with no in_ready gap.
- Backpressure: hold out_ready=0 after a result, then present a beat → in_ready=0 and out_sum is stable. Raise out_ready together with a last beat 4'b1111 → the result is replaced in one cycle by out_sum=4.
- Overflow: ACC_W=3, WIDTH=4, beats 4'b1111, 4'b1111 (last):
  - SAT_EN build → out_sum=7, out_ovf=1.
  - Non-SAT build → out_sum=0, out_ovf=1.
- Reset mid-frame: after 2 beats of 4'b1111, pulse rst_n low, then send 4'b0011 (last) → out_sum=2, out_beats=1.
- Random WIDTH=8 frames of 1–20 beats with random valid/ready → out_sum and out_beats match the reference model for every frame. No beat is lost or duplicated.

Source files
------------

// File: rtl/popcount_accum.sv
// popcount_accum: streaming population-count accumulator.
// Each accepted beat adds popcount(in_data) to a per-frame sum. The sum, the
// frame beat count and a sticky overflow flag land in a single-entry output
// register when the in_last beat is accepted.
//
// Build option: define POPCOUNT_ACCUM_SAT_EN to make the frame sum saturate at
// 2^ACC_W-1 instead of wrapping. out_ovf behaves the same in both builds.
//
// Handshake rules, used on both ports: a transfer happens on a rising edge
// where valid && ready are both high. A held result (out_valid=1) stays
// stable until out_ready. in_ready = !out_valid || out_ready, so a new beat,
// including a last beat, can be accepted in the same cycle the held result is
// taken.
module popcount_accum #(
  parameter int WIDTH  = 8,
  parameter int ACC_W  = 16,
  parameter int BEAT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [BEAT_W-1:0] out_beats,
  output logic              out_ovf,
  output logic              dbg_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    pc;
  logic [ACC_W:0]      sum_ext;
  logic                carry;
  logic [ACC_W-1:0]    acc_nxt;
  logic [ACC_W-1:0]    acc_q;
  logic [BEAT_W-1:0]   beats_q;
  logic                ovf_q;
  logic                accept;
  logic                accept_last;

  assign out_valid   = (state_q == ST_FULL);
  assign in_ready    = !out_valid || out_ready;
  assign accept      = in_valid && in_ready;
  assign accept_last = accept && in_last;
  assign dbg_state   = state_q;

  // Combinational popcount of the incoming beat.
  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pc = pc + CNT_W'(in_data[i]);
    end
  end

  // Running sum with one extra bit to expose the carry out of ACC_W.
  always_comb begin
    sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - CNT_W){1'b0}}, pc};
    carry   = sum_ext[ACC_W];
`ifdef POPCOUNT_ACCUM_SAT_EN
    // Once at max, any nonzero pc carries again, so the sum sticks at max.
    acc_nxt = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    acc_nxt = sum_ext[ACC_W-1:0];
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a last beat always (re)fills the output; a taken result
  // without a new last beat frees it.
  always_comb begin
    state_d = state_q;
    if (accept_last) begin
      state_d = ST_FULL;
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d = ST_ACCUM;
    end
  end

  // Frame accumulators and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      beats_q   <= '0;
      ovf_q     <= 1'b0;
      out_sum   <= '0;
      out_beats <= '0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        out_sum   <= acc_nxt;
        out_beats <= beats_q + BEAT_W'(1);
        out_ovf   <= ovf_q | carry;
        acc_q     <= '0;
        beats_q   <= '0;
        ovf_q     <= 1'b0;
      end else begin
        acc_q     <= acc_nxt;
        beats_q   <= beats_q + BEAT_W'(1);
        ovf_q     <= ovf_q | carry;
      end
    end
  end

endmodule

// File: tb/tb_popcount_accum.sv
// tb_popcount_accum: directed checks on a WIDTH=4/ACC_W=3 instance and
// randomized frames on a WIDTH=8 default instance against a frame-level model.
module tb_popcount_accum;

  int tests = 0;
  int fails = 0;

  logic clk = 1'b0;
  logic rst_n;

  // Small instance: WIDTH=4, ACC_W=3 (overflow reachable).
  logic       a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_ovf, a_dbg;
  logic [3:0] a_in_data;
  logic [2:0] a_out_sum;
  logic [7:0] a_out_beats;

  // Default instance: WIDTH=8, ACC_W=16, BEAT_W=8.
  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_ovf, b_dbg;
  logic [7:0]  b_in_data;
  logic [15:0] b_out_sum;
  logic [7:0]  b_out_beats;

  popcount_accum #(.WIDTH(4), .ACC_W(3), .BEAT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum),
    .out_beats(a_out_beats), .out_ovf(a_out_ovf), .dbg_state(a_dbg)
  );

  popcount_accum u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum),
    .out_beats(b_out_beats), .out_ovf(b_out_ovf), .dbg_state(b_dbg)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  // Driver: present one beat on the small instance for one cycle. Entered
  // and left at posedge+1.
  task automatic a_send(input logic [3:0] d, input logic l);
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_in_last  = l;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL reset_a_in_ready got %b want 1", a_in_ready); end
    tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL reset_a_out_valid got %b want 0", a_out_valid); end
    tests++; if ({a_out_sum, a_out_beats, a_out_ovf} !== 12'h0) begin fails++; $display("FAIL reset_a_outputs got sum=%0d beats=%0d ovf=%b want 0", a_out_sum, a_out_beats, a_out_ovf); end
    tests++; if ({b_out_valid, b_out_sum, b_out_beats, b_out_ovf} !== 26'h0 || b_in_ready !== 1'b1) begin fails++; $display("FAIL reset_b_outputs got v=%b sum=%0d beats=%0d ovf=%b rdy=%b", b_out_valid, b_out_sum, b_out_beats, b_out_ovf, b_in_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_frame();
    a_out_ready = 1'b1;
    a_send(4'b1111, 1'b0);
    a_send(4'b0101, 1'b0);
    a_send(4'b0000, 1'b1);
    tests++; if (a_out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b want 1", a_out_valid); end
    tests++; if (a_out_sum !== 3'd6 || a_out_beats !== 8'd3 || a_out_ovf !== 1'b0) begin fails++; $display("FAIL basic_result got sum=%0d beats=%0d ovf=%b want 6/3/0", a_out_sum, a_out_beats, a_out_ovf); end
    @(posedge clk); #1;
    tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL basic_one_cycle got valid=%b want 0", a_out_valid); end
  endtask

  task automatic test_back_to_back();
    a_out_ready = 1'b1;
    a_send(4'b1011, 1'b1);
    tests++; if (a_out_valid !== 1'b1 || a_out_sum !== 3'd3 || a_out_beats !== 8'd1) begin fails++; $display("FAIL single_beat got v=%b sum=%0d beats=%0d want 1/3/1", a_out_valid, a_out_sum, a_out_beats); end
    a_in_valid = 1'b1; a_in_data = 4'b0001; a_in_last = 1'b1;
    #1;
    tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready got %b want 1", a_in_ready); end
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_in_last = 1'b0;
    tests++; if (a_out_valid !== 1'b1 || a_out_sum !== 3'd1 || a_out_beats !== 8'd1) begin fails++; $display("FAIL b2b_result got v=%b sum=%0d beats=%0d want 1/1/1", a_out_valid, a_out_sum, a_out_beats); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b0;
    a_send(4'b0011, 1'b1);
    a_in_valid = 1'b1; a_in_data = 4'b1111; a_in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (a_in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %b want 0", a_in_ready); end
      tests++; if (a_out_valid !== 1'b1 || a_out_sum !== 3'd2 || a_out_beats !== 8'd1) begin fails++; $display("FAIL bp_hold got v=%b sum=%0d beats=%0d want 1/2/1", a_out_valid, a_out_sum, a_out_beats); end
      @(posedge clk); #1;
      a_in_data = 4'($urandom_range(0, 15));
      a_in_last = 1'($urandom_range(0, 1));
    end
    a_out_ready = 1'b1; a_in_data = 4'b1111; a_in_last = 1'b1;
    #1;
    tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %b want 1", a_in_ready); end
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_in_last = 1'b0;
    tests++; if (a_out_valid !== 1'b1 || a_out_sum !== 3'd4 || a_out_beats !== 8'd1) begin fails++; $display("FAIL bp_replace got v=%b sum=%0d beats=%0d want 1/4/1", a_out_valid, a_out_sum, a_out_beats); end
    @(posedge clk); #1;
    tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got valid=%b want 0", a_out_valid); end
  endtask

  task automatic test_overflow();
    logic [2:0] exp_sum;
`ifdef POPCOUNT_ACCUM_SAT_EN
    exp_sum = 3'd7;
`else
    exp_sum = 3'd0;
`endif
    a_out_ready = 1'b1;
    a_send(4'b1111, 1'b0);
    a_send(4'b1111, 1'b1);
    tests++; if (a_out_valid !== 1'b1 || a_out_sum !== exp_sum || a_out_ovf !== 1'b1 || a_out_beats !== 8'd2) begin fails++; $display("FAIL overflow got v=%b sum=%0d ovf=%b beats=%0d want 1/%0d/1/2", a_out_valid, a_out_sum, a_out_ovf, a_out_beats, exp_sum); end
    a_send(4'b0001, 1'b1);
    tests++; if (a_out_sum !== 3'd1 || a_out_ovf !== 1'b0) begin fails++; $display("FAIL ovf_cleared got sum=%0d ovf=%b want 1/0", a_out_sum, a_out_ovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    a_out_ready = 1'b1;
    a_send(4'b1111, 1'b0);
    a_send(4'b1111, 1'b0);
    rst_n = 1'b0;
    #2;
    tests++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_sum !== 3'd0) begin fails++; $display("FAIL midreset_outputs got v=%b rdy=%b sum=%0d want 0/1/0", a_out_valid, a_in_ready, a_out_sum); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    a_send(4'b0011, 1'b1);
    tests++; if (a_out_valid !== 1'b1 || a_out_sum !== 3'd2 || a_out_beats !== 8'd1) begin fails++; $display("FAIL midreset_frame got v=%b sum=%0d beats=%0d want 1/2/1", a_out_valid, a_out_sum, a_out_beats); end
    @(posedge clk); #1;
  endtask

  // Randomized frames on the WIDTH=8 instance with a frame-level scoreboard.
  task automatic test_random_frames();
    localparam int NF = 40;
    logic [7:0]  beat_q[$];
    logic        last_q[$];
    logic [15:0] exp_q[$];
    logic [7:0]  exp_beats_q[$];
    int idx = 0, got = 0, cycles = 0;
    logic took;
    for (int f = 0; f < NF; f++) begin
      int len = $urandom_range(1, 20);
      int total = 0;
      for (int k = 0; k < len; k++) begin
        logic [7:0] d = 8'($urandom);
        beat_q.push_back(d);
        last_q.push_back(k == len - 1);
        total += $countones(d);
      end
      exp_q.push_back(16'(total));
      exp_beats_q.push_back(8'(len));
    end
    while (got < NF && cycles < 20000) begin
      if (idx < beat_q.size() && !b_in_valid && $urandom_range(0, 3) != 0) begin
        b_in_valid = 1'b1; b_in_data = beat_q[idx]; b_in_last = last_q[idx];
      end
      b_out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = b_in_valid && b_in_ready;
      tests++; if (b_in_ready !== (!b_out_valid || b_out_ready)) begin fails++; $display("FAIL rand_in_ready got %b want %b", b_in_ready, !b_out_valid || b_out_ready); end
      if (b_out_valid && b_out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL rand_extra_frame got sum=%0d want none", b_out_sum);
        end else begin
          logic [15:0] es = exp_q.pop_front();
          logic [7:0]  eb = exp_beats_q.pop_front();
          if (b_out_sum !== es || b_out_beats !== eb || b_out_ovf !== 1'b0) begin
            fails++; $display("FAIL rand_frame%0d got sum=%0d beats=%0d ovf=%b want %0d/%0d/0", got, b_out_sum, b_out_beats, b_out_ovf, es, eb);
          end
        end
        got++;
      end
      @(posedge clk); #1;
      if (took) begin idx++; b_in_valid = 1'b0; b_in_last = 1'b0; end
      cycles++;
    end
    tests++; if (got != NF || idx != beat_q.size()) begin fails++; $display("FAIL rand_completion got frames=%0d beats=%0d want %0d/%0d", got, idx, NF, beat_q.size()); end
    b_out_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_last = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_mid_reset();
    test_random_frames();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
